// File: rtl/para_fir_pkg.sv
// para_fir_pkg: shared constants, loader state encoding and width helper for the parallel FIR.
// Rev 1.0
`default_nettype none

package para_fir_pkg;

  localparam int COEFF_W = 18;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOAD    = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_PENDING = 2'd3;

  // Bits needed to index n items, never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/para_fir_coeff_loader.sv
// para_fir_coeff_loader: assembles streamed coefficients in a shadow bank and swaps them
// into the active vector atomically on a qualified swap strobe. Rev 1.0
`default_nettype none

module para_fir_coeff_loader #(
  parameter int taps = 9,
  parameter int COEFF_W = para_fir_pkg::COEFF_W,
  parameter logic [COEFF_W*taps-1:0] RESET_COEFF = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [COEFF_W-1:0]        cfg_data_i,
  input  logic                      cfg_valid_i,
  input  logic                      cfg_last_i,
  output logic                      cfg_ready_o,
  input  logic                      swap_en_i,
  input  logic                      err_clr_i,
  output logic [COEFF_W*taps-1:0]   coeff_o,
  output logic                      update_o,
  output logic                      pending_o,
  output logic                      err_short_o,
  output logic                      err_long_o
);

  import para_fir_pkg::*;

  localparam int CNT_W = clog2(taps);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(taps - 1);

  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [COEFF_W-1:0]      shadow_q [taps];
  logic [COEFF_W-1:0]      shadow_d [taps];
  logic [COEFF_W*taps-1:0] coeff_q, coeff_d;
  logic                    update_q, update_d;
  logic                    err_short_q, err_short_d;
  logic                    err_long_q, err_long_d;

  logic accept;
  logic set_short;
  logic set_long;
  logic clear_shadow;

  assign accept = cfg_valid_i && (state_q != ST_PENDING);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    coeff_d      = coeff_q;
    update_d     = 1'b0;
    set_short    = 1'b0;
    set_long     = 1'b0;
    clear_shadow = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cfg_last_i && (taps > 1)) begin
            set_short    = 1'b1;
            clear_shadow = 1'b1;
          end else begin
            shadow_d[0] = cfg_data_i;
            if (taps == 1) begin
              // A one-tap frame is complete (or already overlong) on its first word.
              if (cfg_last_i) begin
                state_d = ST_PENDING;
              end else begin
                set_long = 1'b1;
                state_d  = ST_DRAIN;
              end
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = ST_LOAD;
            end
          end
        end
      end

      ST_LOAD: begin
        if (accept) begin
          if (cnt_q == LAST_IDX) begin
            for (int k = 0; k < taps; k++) begin
              if (cnt_q == CNT_W'(k)) shadow_d[k] = cfg_data_i;
            end
            if (cfg_last_i) begin
              state_d = ST_PENDING;
            end else begin
              set_long = 1'b1;
              state_d  = ST_DRAIN;
            end
          end else if (cfg_last_i) begin
            set_short    = 1'b1;
            clear_shadow = 1'b1;
            cnt_d        = '0;
            state_d      = ST_IDLE;
          end else begin
            for (int k = 0; k < taps; k++) begin
              if (cnt_q == CNT_W'(k)) shadow_d[k] = cfg_data_i;
            end
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_DRAIN: begin
        if (accept && cfg_last_i) begin
          clear_shadow = 1'b1;
          cnt_d        = '0;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        if (swap_en_i) begin
          for (int k = 0; k < taps; k++) begin
            coeff_d[COEFF_W*(taps-k)-1 -: COEFF_W] = shadow_q[k];
          end
          update_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end
      end
    endcase

    if (clear_shadow) begin
      for (int k = 0; k < taps; k++) shadow_d[k] = '0;
    end

    // A fresh error in the same cycle as a clear must survive.
    err_short_d = (err_short_q && !err_clr_i) || set_short;
    err_long_d  = (err_long_q && !err_clr_i) || set_long;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      coeff_q     <= RESET_COEFF;
      update_q    <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      for (int k = 0; k < taps; k++) shadow_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      coeff_q     <= coeff_d;
      update_q    <= update_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      shadow_q    <= shadow_d;
    end
  end

  assign cfg_ready_o = (state_q != ST_PENDING);
  assign pending_o   = (state_q == ST_PENDING);
  assign coeff_o     = coeff_q;
  assign update_o    = update_q;
  assign err_short_o = err_short_q;
  assign err_long_o  = err_long_q;

endmodule

`default_nettype wire

// File: tb/tb_para_fir_coeff_loader.sv
// tb_para_fir_coeff_loader: directed and random frames checked against a frame-level model.
// Rev 1.0
`default_nettype none

module tb_para_fir_coeff_loader;

  localparam int T = 9;

  function automatic logic [18*T-1:0] mk_rst();
    logic [18*T-1:0] v;
    for (int k = 0; k < T; k++) v[18*(T-k)-1 -: 18] = 18'(256 + k);
    return v;
  endfunction

  localparam logic [18*T-1:0] RST_VEC = mk_rst();

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_i = 1'b1;
  logic [17:0]     cfg_data_i = '0;
  logic            cfg_valid_i = 1'b0;
  logic            cfg_last_i = 1'b0;
  logic            swap_en_i = 1'b0;
  logic            err_clr_i = 1'b0;
  logic            cfg_ready_o;
  logic [18*T-1:0] coeff_o;
  logic            update_o, pending_o, err_short_o, err_long_o;

  logic [17:0] d1 = '0;
  logic        v1 = 1'b0, l1 = 1'b0, sw1 = 1'b0, clr1 = 1'b0;
  logic        ready1, update1, pending1, es1, el1;
  logic [17:0] coeff1;

  para_fir_coeff_loader #(.taps(T), .COEFF_W(18), .RESET_COEFF(RST_VEC)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .cfg_data_i(cfg_data_i), .cfg_valid_i(cfg_valid_i),
    .cfg_last_i(cfg_last_i), .cfg_ready_o(cfg_ready_o), .swap_en_i(swap_en_i),
    .err_clr_i(err_clr_i), .coeff_o(coeff_o), .update_o(update_o), .pending_o(pending_o),
    .err_short_o(err_short_o), .err_long_o(err_long_o)
  );

  para_fir_coeff_loader #(.taps(1), .COEFF_W(18), .RESET_COEFF(18'h0)) u_dut1 (
    .clk_i(clk), .rst_i(rst_i), .cfg_data_i(d1), .cfg_valid_i(v1),
    .cfg_last_i(l1), .cfg_ready_o(ready1), .swap_en_i(sw1),
    .err_clr_i(clr1), .coeff_o(coeff1), .update_o(update1), .pending_o(pending1),
    .err_short_o(es1), .err_long_o(el1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: words collect in a queue; a frame's fate is decided by its length.
  logic [17:0] m_active [T];
  logic [17:0] m_shadow [T];
  logic [17:0] frame [$];
  bit m_pend, m_drain, m_upd, m_es, m_el;

  function automatic logic [18*T-1:0] model_vec();
    logic [18*T-1:0] v;
    for (int k = 0; k < T; k++) v[18*(T-k)-1 -: 18] = m_active[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < T; k++) m_active[k] = 18'(256 + k);
    frame.delete();
    m_pend = 0; m_drain = 0; m_upd = 0; m_es = 0; m_el = 0;
  endtask

  task automatic tick(input bit rst, input bit v, input logic [17:0] d, input bit l,
                      input bit sw, input bit clr);
    bit ss, sl;
    ss = 0; sl = 0;
    rst_i = rst; cfg_valid_i = v; cfg_data_i = d; cfg_last_i = l;
    swap_en_i = sw; err_clr_i = clr;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_upd = 0;
      if (m_pend) begin
        if (sw) begin
          for (int k = 0; k < T; k++) m_active[k] = m_shadow[k];
          m_upd = 1; m_pend = 0;
        end
      end else if (v) begin
        if (m_drain) begin
          if (l) m_drain = 0;
        end else begin
          frame.push_back(d);
          if (l) begin
            if (frame.size() == T) begin
              for (int k = 0; k < T; k++) m_shadow[k] = frame[k];
              m_pend = 1;
            end else begin
              ss = 1;
            end
            frame.delete();
          end else if (frame.size() == T) begin
            sl = 1; m_drain = 1;
            frame.delete();
          end
        end
      end
      m_es = (m_es && !clr) || ss;
      m_el = (m_el && !clr) || sl;
    end
    #1;
    chk("ready", cfg_ready_o, !m_pend);
    chk("pending", pending_o, m_pend);
    chk("update", update_o, m_upd);
    chk("coeff", coeff_o, model_vec());
    chk("err_short", err_short_o, m_es);
    chk("err_long", err_long_o, m_el);
  endtask

  task automatic idle(input int n, input bit sw);
    for (int i = 0; i < n; i++) tick(0, 0, 18'h0, 0, sw, 0);
  endtask

  initial begin
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    chk("rst_coeff", coeff_o, RST_VEC);
    chk("rst_coeff1", coeff1, 18'h0);
    chk("rst_ready1", ready1, 1'b1);

    // Idle with swap strobes: nothing may change.
    idle(20, 1);

    // Normal load 1..9 with swap permitted continuously.
    for (int k = 1; k <= T; k++) tick(0, 1, 18'(k), k == T, 1, 0);
    chk("norm_pending", pending_o, 1'b1);
    tick(0, 0, 0, 0, 1, 0);
    chk("norm_c0", coeff_o[161:144], 18'd1);
    chk("norm_c8", coeff_o[17:0], 18'd9);
    chk("norm_upd", update_o, 1'b1);
    idle(3, 1);

    // Deferred swap with extra words offered while pending.
    for (int k = 1; k <= T; k++) tick(0, 1, 18'h3FFFF, k == T, 0, 0);
    for (int i = 0; i < 50; i++) tick(0, 1, 18'h12345, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 0);
    chk("defer_upd", update_o, 1'b1);
    idle(2, 0);

    // Short frame, then a good frame, then clear.
    for (int k = 1; k <= 5; k++) tick(0, 1, 18'(16 + k), k == 5, 0, 0);
    chk("short_flag", err_short_o, 1'b1);
    for (int k = 1; k <= T; k++) tick(0, 1, 18'(32 + k), k == T, 0, 0);
    tick(0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0, 1);
    chk("short_clr", err_short_o, 1'b0);

    // Long frame: 12 words, last on 12.
    for (int k = 1; k <= 12; k++) tick(0, 1, 18'(64 + k), k == 12, 1, 0);
    chk("long_flag", err_long_o, 1'b1);
    idle(3, 1);
    tick(0, 0, 0, 0, 0, 1);

    // Reset in the middle of a load, then a fresh load.
    for (int k = 1; k <= 4; k++) tick(0, 1, 18'(128 + k), 0, 1, 0);
    tick(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= T; k++) tick(0, 1, 18'(200 + k), k == T, 1, 0);
    tick(0, 0, 0, 0, 1, 0);
    chk("rstmid_c0", coeff_o[161:144], 18'd201);

    // Single-tap build.
    d1 = 18'h2ABCD; v1 = 1; l1 = 1;
    idle(1, 0);
    chk("t1_pending", pending1, 1'b1);
    chk("t1_ready", ready1, 1'b0);
    v1 = 0; l1 = 0; sw1 = 1;
    idle(1, 0);
    chk("t1_upd", update1, 1'b1);
    chk("t1_coeff", coeff1, 18'h2ABCD);
    sw1 = 0;
    idle(1, 0);
    chk("t1_upd_end", update1, 1'b0);
    d1 = 18'h11111; v1 = 1;
    idle(1, 0);
    chk("t1_long", el1, 1'b1);
    l1 = 1;
    idle(1, 0);
    v1 = 0; l1 = 0; sw1 = 1;
    idle(1, 0);
    chk("t1_nopend", pending1, 1'b0);
    chk("t1_keep", coeff1, 18'h2ABCD);
    sw1 = 0;

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 249) == 0, $urandom_range(0, 3) != 0, 18'($urandom),
           $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 19) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
